// File: rtl/cgia_bus_arbiter.sv
// cgia_bus_arbiter: shares the 16-bit video-memory Wishbone slave between the CGIA fetcher and the CPU.
// Optional feature macro CGIA_ARB_ROUND_ROBIN_EN: a CPU that waited through a fetch burst wins the next grant.
module cgia_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        v_cyc_i,
  input  logic [23:1] v_adr_i,
  output logic        v_ack_o,
  output logic [15:0] v_dat_o,
  output logic        v_err_o,
  input  logic        c_cyc_i,
  input  logic        c_stb_i,
  input  logic        c_we_i,
  input  logic [1:0]  c_sel_i,
  input  logic [23:1] c_adr_i,
  input  logic [15:0] c_dat_i,
  output logic        c_ack_o,
  output logic [15:0] c_dat_o,
  output logic        c_err_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [1:0]  m_sel_o,
  output logic [23:1] m_adr_o,
  output logic [15:0] m_dat_o,
  input  logic        m_ack_i,
  input  logic [15:0] m_dat_i,
  output logic [1:0]  gnt_o
);

  typedef enum logic [1:0] {
    GNT_IDLE = 2'b00,
    GNT_VID  = 2'b01,
    GNT_CPU  = 2'b10
  } gnt_t;

  localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT_CYCLES);

  gnt_t        r_gnt;
  gnt_t        w_gnt_next;
  logic [15:0] r_wdt;
  logic        w_pending;
  logic        w_hold_cyc;
  logic        w_timeout;

  // A holder keeps the bus while its cyc is high; a free bus goes to the fetcher unless the CPU is owed a turn.
  function automatic gnt_t f_next_gnt(input gnt_t cur, input logic v_req, input logic c_req,
                                      input logic cpu_first);
    gnt_t nxt;
    nxt = GNT_IDLE;
    case (cur)
      GNT_VID: nxt = v_req ? GNT_VID : (c_req ? GNT_CPU : GNT_IDLE);
      GNT_CPU: nxt = c_req ? GNT_CPU : (v_req ? GNT_VID : GNT_IDLE);
      GNT_IDLE: begin
        if (c_req && (cpu_first || !v_req)) nxt = GNT_CPU;
        else if (v_req)                     nxt = GNT_VID;
        else                                nxt = GNT_IDLE;
      end
      default: nxt = GNT_IDLE;
    endcase
    return nxt;
  endfunction

  assign w_gnt_next = f_next_gnt(r_gnt, v_cyc_i, c_cyc_i, w_pending);
  // An acknowledge in the timeout cycle wins over the error.
  assign w_timeout  = (LP_TIMEOUT != 16'd0) && (r_wdt == LP_TIMEOUT) && !m_ack_i;

`ifdef CGIA_ARB_ROUND_ROBIN_EN
  logic r_cpu_pending;

  // Remember a CPU request seen during a fetch burst until the CPU is granted.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                               r_cpu_pending <= 1'b0;
    else if (w_gnt_next == GNT_CPU)            r_cpu_pending <= 1'b0;
    else if ((r_gnt == GNT_VID) && c_cyc_i)    r_cpu_pending <= 1'b1;
    else                                       r_cpu_pending <= r_cpu_pending;
  end

  assign w_pending = r_cpu_pending;
`else
  assign w_pending = 1'b0;
`endif

  // Grant state and bus watchdog.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_gnt <= GNT_IDLE;
      r_wdt <= 16'd0;
    end else begin
      r_gnt <= w_gnt_next;
      if ((w_gnt_next != r_gnt) || m_ack_i || !w_hold_cyc || w_timeout) r_wdt <= 16'd0;
      else                                                             r_wdt <= r_wdt + 16'd1;
    end
  end

  // Memory-side mux of the granted master; cyc/stb are dropped in the timeout cycle.
  always_comb begin
    w_hold_cyc = 1'b0;
    m_cyc_o    = 1'b0;
    m_stb_o    = 1'b0;
    m_we_o     = 1'b0;
    m_sel_o    = 2'b00;
    m_adr_o    = 23'd0;
    m_dat_o    = 16'd0;
    case (r_gnt)
      GNT_VID: begin
        w_hold_cyc = v_cyc_i;
        m_cyc_o    = v_cyc_i & ~w_timeout;
        m_stb_o    = v_cyc_i & ~w_timeout;
        m_sel_o    = 2'b11;
        m_adr_o    = v_adr_i;
      end
      GNT_CPU: begin
        w_hold_cyc = c_cyc_i;
        m_cyc_o    = c_cyc_i & ~w_timeout;
        m_stb_o    = c_stb_i & ~w_timeout;
        m_we_o     = c_we_i;
        m_sel_o    = c_sel_i;
        m_adr_o    = c_adr_i;
        m_dat_o    = c_dat_i;
      end
      default: begin
        w_hold_cyc = 1'b0;
      end
    endcase
  end

  assign v_ack_o = (r_gnt == GNT_VID) & m_ack_i;
  assign c_ack_o = (r_gnt == GNT_CPU) & m_ack_i;
  assign v_err_o = (r_gnt == GNT_VID) & w_timeout;
  assign c_err_o = (r_gnt == GNT_CPU) & w_timeout;
  assign v_dat_o = m_dat_i;
  assign c_dat_o = m_dat_i;
  assign gnt_o   = r_gnt;

endmodule

// File: tb/tb_cgia_bus_arbiter.sv
// Scoreboard bench for cgia_bus_arbiter: a rule-level grant/watchdog model queues the expected bus view
// for every cycle and a negedge monitor compares it with the DUT.
module tb_cgia_bus_arbiter;

  localparam int TO = 4;
`ifdef CGIA_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_i;
  logic        v_cyc_i;
  logic [23:1] v_adr_i;
  logic        v_ack_o;
  logic [15:0] v_dat_o;
  logic        v_err_o;
  logic        c_cyc_i;
  logic        c_stb_i;
  logic        c_we_i;
  logic [1:0]  c_sel_i;
  logic [23:1] c_adr_i;
  logic [15:0] c_dat_i;
  logic        c_ack_o;
  logic [15:0] c_dat_o;
  logic        c_err_o;
  logic        m_cyc_o;
  logic        m_stb_o;
  logic        m_we_o;
  logic [1:0]  m_sel_o;
  logic [23:1] m_adr_o;
  logic [15:0] m_dat_o;
  logic        m_ack_i;
  logic [15:0] m_dat_i;
  logic [1:0]  gnt_o;

  cgia_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .v_cyc_i(v_cyc_i), .v_adr_i(v_adr_i), .v_ack_o(v_ack_o), .v_dat_o(v_dat_o), .v_err_o(v_err_o),
    .c_cyc_i(c_cyc_i), .c_stb_i(c_stb_i), .c_we_i(c_we_i), .c_sel_i(c_sel_i), .c_adr_i(c_adr_i),
    .c_dat_i(c_dat_i), .c_ack_o(c_ack_o), .c_dat_o(c_dat_o), .c_err_o(c_err_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o), .m_adr_o(m_adr_o),
    .m_dat_o(m_dat_o), .m_ack_i(m_ack_i), .m_dat_i(m_dat_i), .gnt_o(gnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  gnt;
    logic [43:0] mbus;   // {cyc, stb, we, sel, adr, dat}
    logic [3:0]  ae;     // {v_ack, c_ack, v_err, c_err}
    logic [15:0] md;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: owner 0 none, 1 fetcher, 2 CPU; wait = unacknowledged cycles of the current holder.
  int   owner = 0;
  int   wait_cnt = 0;
  bit   owed = 1'b0;
  bit   stall = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, req);
    end
  endtask

  function automatic bit timed_out();
    return (TO != 0) && (wait_cnt == TO) && !m_ack_i;
  endfunction

  task automatic push_expect();
    exp_t e;
    bit   to;
    if (reset_i) begin
      owner = 0; wait_cnt = 0; owed = 1'b0;
    end
    to    = timed_out();
    e.gnt = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
    if (owner == 1)
      e.mbus = {v_cyc_i && !to, v_cyc_i && !to, 1'b0, 2'b11, v_adr_i, 16'h0000};
    else if (owner == 2)
      e.mbus = {c_cyc_i && !to, c_stb_i && !to, c_we_i, c_sel_i, c_adr_i, c_dat_i};
    else
      e.mbus = 44'd0;
    e.ae = {owner == 1 && m_ack_i, owner == 2 && m_ack_i, owner == 1 && to, owner == 2 && to};
    e.md = m_dat_i;
    exp_q.push_back(e);
  endtask

  task automatic model_step();
    bit to, holding;
    int nxt;
    if (reset_i) begin
      owner = 0; wait_cnt = 0; owed = 1'b0;
    end else begin
      to      = timed_out();
      holding = (owner == 1 && v_cyc_i) || (owner == 2 && c_cyc_i);
      if (holding)                nxt = owner;
      else if (v_cyc_i && c_cyc_i) nxt = (RR && owed) ? 2 : 1;
      else if (v_cyc_i)           nxt = 1;
      else if (c_cyc_i)           nxt = 2;
      else                        nxt = 0;
      if (RR) begin
        if (nxt == 2)                   owed = 1'b0;
        else if (owner == 1 && c_cyc_i) owed = 1'b1;
      end
      if (nxt != owner || m_ack_i || !holding || to) wait_cnt = 0;
      else                                           wait_cnt = wait_cnt + 1;
      owner = nxt;
    end
  endtask

  task automatic cyc_end();
    push_expect();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc_end();
  endtask

  // Monitor: one expected bus view per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("gnt", 64'(gnt_o), 64'(mon_e.gnt));
      chk("mbus", 64'({m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o}), 64'(mon_e.mbus));
      chk("ack_err", 64'({v_ack_o, c_ack_o, v_err_o, c_err_o}), 64'(mon_e.ae));
      if (mon_e.ae[3]) chk("v_dat", 64'(v_dat_o), 64'(mon_e.md));
      if (mon_e.ae[2]) chk("c_dat", 64'(c_dat_o), 64'(mon_e.md));
    end
  end

  initial begin
    reset_i = 1'b1; v_cyc_i = 1'b0; v_adr_i = 23'd0; c_cyc_i = 1'b0; c_stb_i = 1'b0;
    c_we_i = 1'b0; c_sel_i = 2'b00; c_adr_i = 23'd0; c_dat_i = 16'd0; m_ack_i = 1'b0; m_dat_i = 16'd0;
    @(posedge clk); #1;

    // Reset with both masters requesting and a stray ack, then release.
    v_cyc_i = 1'b1; c_cyc_i = 1'b1; c_stb_i = 1'b1; m_ack_i = 1'b1; m_dat_i = 16'hBEEF;
    run(2);
    reset_i = 1'b0; m_ack_i = 1'b0; v_adr_i = 23'h7F8000;
    run(1);
    // Fetcher priority: six acknowledged beats with the CPU waiting.
    m_ack_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      m_dat_i = 16'h1000 + 16'(k);
      cyc_end();
    end
    // Handoff to a pending CPU write.
    v_cyc_i = 1'b0; m_ack_i = 1'b0; c_we_i = 1'b1; c_sel_i = 2'b01; c_adr_i = 23'h001234; c_dat_i = 16'h1234;
    run(1);
    m_ack_i = 1'b1;
    run(1);
    c_cyc_i = 1'b0; c_stb_i = 1'b0; c_we_i = 1'b0; m_ack_i = 1'b0;
    run(1);
    // Wait states: three unacknowledged cycles then an ack.
    v_cyc_i = 1'b1; v_adr_i = 23'h012345;
    run(4);
    m_ack_i = 1'b1; m_dat_i = 16'h5A5A;
    run(1);
    v_cyc_i = 1'b0; m_ack_i = 1'b0;
    run(1);
    // Timeout on a stuck CPU cycle, then an ack landing on the timeout count.
    c_cyc_i = 1'b1; c_stb_i = 1'b1; c_sel_i = 2'b11; c_adr_i = 23'h000042;
    run(6);
    c_cyc_i = 1'b0; c_stb_i = 1'b0;
    run(1);
    c_cyc_i = 1'b1; c_stb_i = 1'b1;
    run(5);
    m_ack_i = 1'b1; m_dat_i = 16'hC0DE;
    run(1);
    c_cyc_i = 1'b0; c_stb_i = 1'b0; m_ack_i = 1'b0;
    run(1);
    // Fairness: CPU asks during a fetch burst, then both request from idle.
    v_cyc_i = 1'b1; m_ack_i = 1'b1;
    run(1);
    c_cyc_i = 1'b1; c_stb_i = 1'b1;
    run(2);
    c_cyc_i = 1'b0; c_stb_i = 1'b0;
    run(1);
    v_cyc_i = 1'b0; m_ack_i = 1'b0;
    run(1);
    v_cyc_i = 1'b1; c_cyc_i = 1'b1; c_stb_i = 1'b1;
    run(3);
    v_cyc_i = 1'b0; c_cyc_i = 1'b0; c_stb_i = 1'b0;
    run(2);

    // Randomized traffic with occasional slave stalls and resets.
    for (int i = 0; i < 3000; i++) begin
      v_cyc_i = v_cyc_i ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 2) == 0);
      c_cyc_i = c_cyc_i ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 2) == 0);
      c_stb_i = c_cyc_i && ($urandom_range(0, 3) != 0);
      c_we_i  = 1'($urandom());
      c_sel_i = 2'($urandom());
      v_adr_i = 23'($urandom());
      c_adr_i = 23'($urandom());
      c_dat_i = 16'($urandom());
      if ($urandom_range(0, 19) == 0) stall = !stall;
      m_ack_i = !stall && ($urandom_range(0, 2) != 0);
      m_dat_i = 16'($urandom());
      reset_i = ($urandom_range(0, 499) == 0);
      cyc_end();
    end

    reset_i = 1'b0; v_cyc_i = 1'b0; c_cyc_i = 1'b0; c_stb_i = 1'b0; m_ack_i = 1'b0;
    run(3);
    @(negedge clk); #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cgia_bus_arbiter.md
# cgia_bus_arbiter

- Shares the single 16-bit video-memory Wishbone slave port between two masters:
  - the CGIA fetcher (video DMA, read-only);
  - the host CPU port.
- The fetcher has priority because missed line fetches corrupt the display. The CPU is serviced between bursts.
- A bus watchdog ends cycles that a slave never acknowledges.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 255: wait-state cycles before a bus error is raised; 0 disables the watchdog.

Ports:
- `clk_i` in 1: single system clock.
- `reset_i` in 1: asynchronous, active-high reset.
- `v_cyc_i` in 1: fetcher bus request / cycle.
- `v_adr_i` in 23 [23:1]: fetcher word address.
- `v_ack_o` out 1: fetcher acknowledge.
- `v_dat_o` out 16: fetcher read data.
- `v_err_o` out 1: fetcher bus error (timeout).
- `c_cyc_i` in 1: CPU cycle.
- `c_stb_i` in 1: CPU strobe.
- `c_we_i` in 1: CPU write enable.
- `c_sel_i` in 2: CPU byte lanes.
- `c_adr_i` in 23 [23:1]: CPU word address.
- `c_dat_i` in 16: CPU write data.
- `c_ack_o` out 1: CPU acknowledge.
- `c_dat_o` out 16: CPU read data.
- `c_err_o` out 1: CPU bus error.
- `m_cyc_o` out 1: memory-side cycle.
- `m_stb_o` out 1: memory-side strobe.
- `m_we_o` out 1: memory-side write enable.
- `m_sel_o` out 2: memory-side byte lanes.
- `m_adr_o` out 23 [23:1]: memory-side word address.
- `m_dat_o` out 16: memory-side write data.
- `m_ack_i` in 1: memory acknowledge.
- `m_dat_i` in 16: memory read data.
- `gnt_o` out 2: current grant; 00 idle, 01 fetcher, 10 CPU.

## Operation

Grant state is registered: IDLE, VID, CPU.

Next-state rule, evaluated each rising edge:
- **Holder still requesting:** if the current holder still asserts its `cyc`, the grant is kept. There is no preemption mid-burst.
- **Holder released, other master requesting:** the grant passes to the requester on the same edge, with zero idle cycles. If both are requesting, VID wins (see Configuration for the round-robin exception).
- **No requests:** the grant goes to IDLE.

Memory-side outputs are combinational muxes of the granted master:
- **VID:** `m_cyc_o`=`v_cyc_i`, `m_stb_o`=`v_cyc_i`, `m_we_o`=0, `m_sel_o`=11, `m_adr_o`=`v_adr_i`, `m_dat_o`=0.
- **CPU:** the `c_*` signals are passed through.
- **IDLE:** all `m_*` outputs are 0.

Acknowledge and read data:
- `m_ack_i` is routed only to the granted master. The non-granted `ack` is 0.
- `m_dat_i` is fanned out to both `v_dat_o` and `c_dat_o`; only the acknowledged master samples it.

Watchdog:
- A 16-bit counter clears on reset, on any grant change, on `m_ack_i`, and while `m_cyc_o`=0.
- Otherwise it increments each cycle.
- When the count equals `TIMEOUT_CYCLES` (and that value is nonzero), `err_o` of the holder pulses for exactly one cycle. In that cycle `m_cyc_o`/`m_stb_o` are forced 0 and the counter clears.
- The master is expected to drop `cyc` after `err`. Until it does, the grant is held.

## Timing

Reset values: `gnt_o`=00, all `m_*` outputs 0, all `ack`/`err` outputs 0, counter 0. `reset_i` mid-burst immediately negates `m_cyc_o`; no acknowledge is routed.

Latency:
- From `cyc` assertion in IDLE to `m_cyc_o`: one clock (grant on the next edge).
- Handoff between masters: `m_cyc_o` may stay high across the boundary, with address switching at the edge.

`ack` is combinational pass-through: zero added latency per beat, and wait states are preserved.

The CPU master must hold `c_cyc_i` through its whole transaction. The arbiter never splits a locked sequence.

Simultaneous events:
- **Release and request on the same edge:** the releasing master cannot re-win against a pending other master if it has dropped `cyc`.
- **`ack` and timeout on the same cycle:** `ack` wins, the counter clears, and no `err` is raised.

## Configuration

`CGIA_ARB_ROUND_ROBIN_EN`:
- **Defined:**
  - After a VID burst ends, if the CPU was requesting at any point during that burst, the CPU gets the next grant even when `v_cyc_i` is re-asserted on the same edge.
  - A sticky `cpu_pending` flag records this; it clears when the CPU is granted.
- **Undefined:**
  - Strict VID priority.
  - The CPU waits until `v_cyc_i` is low at an edge with the grant free.

## Test plan

- **Reset:** assert `reset_i` with both `cyc` inputs high -> `gnt_o`=00, `m_cyc_o`=0, all `ack` outputs 0; release -> next edge `gnt_o`=01.
- **Priority:** both request from IDLE -> `gnt_o`=01, `m_adr_o`=`v_adr_i` ($7F8000 for byte address $FF0000), `m_we_o`=0, `m_sel_o`=11, `c_ack_o`=0 for 6 acknowledged beats.
- **Handoff:** VID drops `cyc` with CPU pending -> same edge `gnt_o`=10, `m_adr_o`=`c_adr_i`. A CPU write of $1234 with `sel`=01 appears on `m_dat_o`/`m_sel_o`.
- **Wait states:** `m_ack_i` held low 3 cycles -> `v_ack_o` low 3 cycles, address stable, no `err`; `ack` on cycle 4 -> `v_ack_o` 1.
- **Timeout:** `TIMEOUT_CYCLES`=4, `m_ack_i` stuck 0 -> `c_err_o` pulses once, 4 cycles after grant; `m_cyc_o` is 0 that cycle. A simultaneous `ack` at count 4 suppresses `err`.
- **Fairness:** CPU requests mid-burst and VID re-requests at release -> with `CGIA_ARB_ROUND_ROBIN_EN` defined, `gnt_o`=10; without it, `gnt_o`=01.
